// File: rtl/rv32_pkg.sv
// Shared RV32I encodings for the MEM stage: funct3 load/store codes, write-back
// select values, the access FSM states and the MEM/WB register layout.
package rv32_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    localparam logic [1:0] WB_ALU  = 2'd0;
    localparam logic [1:0] WB_LOAD = 2'd1;
    localparam logic [1:0] WB_PC4  = 2'd2;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } mem_state_e;

    typedef struct packed {
        logic [31:0] alu_data;
        logic [31:0] pc_4;
        logic [1:0]  wb_sel;
        logic [4:0]  rd_addr;
        logic        rd_wren;
        logic [31:0] ld_data;
    } mem_wb_t;

    // Size is carried in funct3[1:0] for both loads and stores.
    function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] addr_lo);
        case (funct3[1:0])
            2'b01:   return addr_lo[0];
            2'b10:   return (addr_lo != 2'b00);
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mem_cycle_if.sv
// Data-memory request/acknowledge bus between the MEM stage (master) and memory (slave).
interface mem_cycle_if #(
    parameter int ADDR_W = 32
);
    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       wdata;
    logic [3:0]        bmask;
    logic              ack;
    logic [31:0]       rdata;

    modport master (output req, we, addr, wdata, bmask, input ack, rdata);
    modport slave  (input req, we, addr, wdata, bmask, output ack, rdata);
endinterface

// File: rtl/lsu_align.sv
// Combinational byte-lane logic: store data replication and byte enables,
// load byte/half extraction with sign or zero extension.
module lsu_align
    import rv32_pkg::*;
(
    input  logic [2:0]  i_funct3,
    input  logic [1:0]  i_addr_lo,
    input  logic        i_store,
    input  logic [31:0] i_rs2_data,
    input  logic [31:0] i_rdata,
    output logic [31:0] o_wdata,
    output logic [3:0]  o_bmask,
    output logic [31:0] o_ld_data
);

    logic signed [7:0]  ld_byte;
    logic signed [15:0] ld_half;

    // Store lanes: replicate the narrow datum across the word, enable only its bytes.
    always_comb begin
        o_wdata = i_rs2_data;
        o_bmask = 4'b1111;
        if (i_store) begin
            case (i_funct3[1:0])
                2'b00: begin
                    o_wdata = {4{i_rs2_data[7:0]}};
                    o_bmask = 4'b0001 << i_addr_lo;
                end
                2'b01: begin
                    o_wdata = {2{i_rs2_data[15:0]}};
                    o_bmask = i_addr_lo[1] ? 4'b1100 : 4'b0011;
                end
                default: ;
            endcase
        end
    end

    // Load extract: pick the addressed byte/half, then extend by funct3.
    always_comb begin
        case (i_addr_lo)
            2'd0:    ld_byte = i_rdata[7:0];
            2'd1:    ld_byte = i_rdata[15:8];
            2'd2:    ld_byte = i_rdata[23:16];
            default: ld_byte = i_rdata[31:24];
        endcase
        ld_half = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];
        case (i_funct3)
            F3_LB:   o_ld_data = 32'(ld_byte);
            F3_LH:   o_ld_data = 32'(ld_half);
            F3_LBU:  o_ld_data = {24'd0, ld_byte};
            F3_LHU:  o_ld_data = {16'd0, ld_half};
            default: o_ld_data = i_rdata;
        endcase
    end

endmodule

// File: rtl/mem_cycle.sv
// MEM stage: drives the data-memory handshake, stalls the pipeline while an access
// is outstanding, aborts after MAX_WAIT wait cycles, and holds the MEM/WB register.
module mem_cycle
    import rv32_pkg::*;
#(
    parameter int ADDR_W   = 32,
    parameter int MAX_WAIT = 15
) (
    input  logic        i_clk,
    input  logic        i_rst,
    mem_cycle_if.master dmem,
    input  logic        i_valid_M,
    input  logic [31:0] i_alu_data_M,
    input  logic [31:0] i_pc_4_M,
    input  logic [31:0] i_rs2_data_M,
    input  logic [2:0]  i_funct3_M,
    input  logic        i_mem_rden_M,
    input  logic        i_mem_wren_M,
    input  logic [4:0]  i_rd_addr_M,
    input  logic        i_rd_wren_M,
    input  logic [1:0]  i_wb_sel_M,
    output logic        o_stall_M,
    output logic        o_misalign_M,
    output logic        o_timeout_M,
    output logic [31:0] o_alu_data_W,
    output logic [31:0] o_pc_4_W,
    output logic [1:0]  o_wb_sel_W,
    output logic [4:0]  o_rd_addr_W,
    output logic        o_rd_wren_W,
    output logic [31:0] o_ld_data_M
);

    localparam int CNT_W = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_WAIT);

    mem_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    mem_wb_t          wb_q, wb_d;

    logic        misaligned;
    logic        access;
    logic        req;
    logic        timeout;
    logic        stall;
    logic [31:0] al_wdata;
    logic [3:0]  al_bmask;
    logic [31:0] al_ld_data;

    assign misaligned = (i_mem_rden_M | i_mem_wren_M) & is_misaligned(i_funct3_M, i_alu_data_M[1:0]);
    assign access     = i_valid_M & (i_mem_rden_M | i_mem_wren_M) & ~misaligned;

    lsu_align u_align (
        .i_funct3   (i_funct3_M),
        .i_addr_lo  (i_alu_data_M[1:0]),
        .i_store    (i_mem_wren_M),
        .i_rs2_data (i_rs2_data_M),
        .i_rdata    (dmem.rdata),
        .o_wdata    (al_wdata),
        .o_bmask    (al_bmask),
        .o_ld_data  (al_ld_data)
    );

    // Access FSM: zero-wait completion stays in IDLE, otherwise wait for ack or abort.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        req     = 1'b0;
        timeout = 1'b0;
        case (state_q)
            IDLE: begin
                if (access) begin
                    req = 1'b1;
                    if (!dmem.ack) begin
                        state_d = WAIT;
                        cnt_d   = (MAX_WAIT != 0) ? CNT_W'(1) : '0;
                    end
                end
            end
            WAIT: begin
                if ((MAX_WAIT != 0) && (cnt_q == CNT_MAX)) begin
                    timeout = 1'b1;
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    req = 1'b1;
                    if (dmem.ack) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else if (MAX_WAIT != 0) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        // Outputs read as zero throughout reset, even with a live instruction upstream.
        if (i_rst) begin
            req     = 1'b0;
            timeout = 1'b0;
        end
    end

    assign stall = req & ~dmem.ack;

    assign dmem.req   = req;
    assign dmem.we    = req & i_mem_wren_M;
    assign dmem.addr  = req ? {i_alu_data_M[ADDR_W-1:2], 2'b00} : '0;
    assign dmem.wdata = req ? al_wdata : '0;
    assign dmem.bmask = req ? al_bmask : '0;

    assign o_stall_M    = stall;
    assign o_misalign_M = misaligned & i_valid_M & ~i_rst;
    assign o_timeout_M  = timeout;

    // MEM/WB next value: advance when not stalled, otherwise hold and emit a bubble.
    always_comb begin
        wb_d = wb_q;
        if (stall) begin
            wb_d.rd_wren = 1'b0;
        end else begin
            wb_d.alu_data = i_alu_data_M;
            wb_d.pc_4     = i_pc_4_M;
            wb_d.wb_sel   = i_wb_sel_M;
            wb_d.rd_addr  = i_rd_addr_M;
            wb_d.rd_wren  = i_valid_M & i_rd_wren_M & ~misaligned & ~timeout;
            wb_d.ld_data  = al_ld_data;
        end
    end

    // State, wait counter and MEM/WB register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            wb_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wb_q    <= wb_d;
        end
    end

    assign o_alu_data_W = wb_q.alu_data;
    assign o_pc_4_W     = wb_q.pc_4;
    assign o_wb_sel_W   = wb_q.wb_sel;
    assign o_rd_addr_W  = wb_q.rd_addr;
    assign o_rd_wren_W  = wb_q.rd_wren;
    assign o_ld_data_M  = wb_q.ld_data;

endmodule
